// File: rtl/wts_tone_generator.sv
// -----------------------------------------------------------------------------
// wts_tone_generator
//   Per-channel wavetable tone generator. The sample tick (active) is divided by
//   reg_frequency+1 to step a phase index. On every step the addressed waveform
//   byte is fetched from wave SRAM over a req/ack handshake and held on sample
//   for the volume stage.
//
//   Optional feature: define WTS_TONE_NOISE_EN to add the reg_noise input and a
//   17-bit LFSR noise source (x^17 + x^14 + 1). With reg_noise=1 each step
//   produces a +/- full-scale sample from the LFSR instead of an SRAM fetch.
//
// Ports
//   clk            system clock
//   reset          synchronous reset, active-high
//   active         sample-tick enable, 1-cycle pulse
//   reg_frequency  step period minus one, sampled at each reload
//   reg_key_on     1 = tone running
//   reg_noise      (WTS_TONE_NOISE_EN only) 1 = LFSR noise instead of wavetable
//   sram_req       fetch request, held until sram_ack
//   sram_a         {CH_ID, phase}, stable while sram_req=1
//   sram_ack       arbiter grant, 1-cycle pulse
//   sram_q         signed wave byte, valid the cycle after sram_ack
//   sample         signed sample held for the volume stage
//   sample_valid   1-cycle pulse when sample updates
//   phase          current phase index (status)
// -----------------------------------------------------------------------------
module wts_tone_generator #(
  parameter int FREQ_W  = 12,
  parameter int PHASE_W = 5,
  parameter int CH_W    = 3,
  parameter int CH_ID   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      active,
  input  logic [FREQ_W-1:0]         reg_frequency,
  input  logic                      reg_key_on,
`ifdef WTS_TONE_NOISE_EN
  input  logic                      reg_noise,
`endif
  output logic                      sram_req,
  output logic [PHASE_W+CH_W-1:0]   sram_a,
  input  logic                      sram_ack,
  input  logic signed [7:0]         sram_q,
  output logic signed [7:0]         sample,
  output logic                      sample_valid,
  output logic [PHASE_W-1:0]        phase
);

  localparam logic [CH_W-1:0]    CH_ID_V   = CH_W'(CH_ID);
  localparam logic [FREQ_W-1:0]  FREQ_ONE  = {{(FREQ_W-1){1'b0}}, 1'b1};
  localparam logic [PHASE_W-1:0] PHASE_ONE = {{(PHASE_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t             state_r;
  logic [FREQ_W-1:0]  counter_r;
  logic [PHASE_W-1:0] phase_r;
  logic               key_d_r;
  logic               pend_r;
  logic               discard_r;

  logic               key_rise_s;
  logic               tick_step_s;
  logic               step_s;
  logic               fetch_step_s;
  logic [PHASE_W-1:0] next_phase_s;
  logic               noise_s;
  logic               noise_pulse_s;
  logic               noise_bit_s;

`ifdef WTS_TONE_NOISE_EN
  localparam logic [16:0] LFSR_SEED = 17'h00001;

  logic [16:0] lfsr_r;
  logic        noise_pulse_r;

  // Fibonacci form of x^17 + x^14 + 1: shift left, feedback enters bit 0.
  function automatic logic [16:0] lfsr_next(input logic [16:0] v);
    return {v[15:0], v[16] ^ v[13]};
  endfunction

  // LFSR advances once per noise step; its new bit 0 becomes the sample one clock later
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r        <= LFSR_SEED;
      noise_pulse_r <= 1'b0;
    end else begin
      noise_pulse_r <= step_s & noise_s;
      if (step_s && noise_s) begin
        lfsr_r <= lfsr_next(lfsr_r);
      end else begin
        lfsr_r <= lfsr_r;
      end
    end
  end

  assign noise_s       = reg_noise;
  assign noise_pulse_s = noise_pulse_r;
  assign noise_bit_s   = lfsr_r[0];
`else
  assign noise_s       = 1'b0;
  assign noise_pulse_s = 1'b0;
  assign noise_bit_s   = 1'b0;
`endif

  // Step detection; next_phase_s is the phase value the divider holds after this edge
  always_comb begin
    key_rise_s   = reg_key_on & ~key_d_r;
    tick_step_s  = 1'b0;
    next_phase_s = phase_r;
    if (key_rise_s) begin
      next_phase_s = {PHASE_W{1'b0}};
    end else if (reg_key_on && active && (counter_r == {FREQ_W{1'b0}})) begin
      tick_step_s  = 1'b1;
      next_phase_s = phase_r + PHASE_ONE;
    end else begin
      next_phase_s = phase_r;
    end
    step_s       = key_rise_s | tick_step_s;
    // Noise steps never touch SRAM
    fetch_step_s = step_s & ~noise_s;
  end

  // Period divider, phase index and key-on edge history (frozen while key is off)
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_r <= {FREQ_W{1'b0}};
      phase_r   <= {PHASE_W{1'b0}};
      key_d_r   <= 1'b0;
    end else begin
      key_d_r <= reg_key_on;
      phase_r <= next_phase_s;
      if (key_rise_s || tick_step_s) begin
        counter_r <= reg_frequency;
      end else if (reg_key_on && active) begin
        counter_r <= counter_r - FREQ_ONE;
      end else begin
        counter_r <= counter_r;
      end
    end
  end

  // Fetch FSM with registered handshake and sample outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      pend_r       <= 1'b0;
      discard_r    <= 1'b0;
      sram_req     <= 1'b0;
      sram_a       <= {(PHASE_W+CH_W){1'b0}};
      sample       <= 8'sh00;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!reg_key_on) begin
        sample <= 8'sh00;
      end else if (noise_pulse_s) begin
        sample       <= noise_bit_s ? 8'sh7F : 8'sh80;
        sample_valid <= 1'b1;
      end else begin
        sample <= sample;
      end

      case (state_r)
        ST_IDLE: begin
          discard_r <= 1'b0;
          pend_r    <= 1'b0;
          if (reg_key_on && !noise_s && (fetch_step_s || pend_r)) begin
            state_r  <= ST_REQ;
            sram_req <= 1'b1;
            sram_a   <= {CH_ID_V, next_phase_s};
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_REQ: begin
          // Key-off or a switch to noise invalidates the data of this fetch,
          // but the handshake itself must still complete.
          if (!reg_key_on || noise_s) begin
            discard_r <= 1'b1;
          end else begin
            discard_r <= discard_r;
          end
          // One-deep pending flag: further steps coalesce into it
          pend_r <= reg_key_on & ~noise_s & (pend_r | fetch_step_s);
          if (sram_ack) begin
            state_r  <= ST_DATA;
            sram_req <= 1'b0;
          end else begin
            state_r <= ST_REQ;
          end
        end

        ST_DATA: begin
          if (!discard_r && reg_key_on && !noise_s) begin
            sample       <= sram_q;
            sample_valid <= 1'b1;
          end else begin
            sample_valid <= 1'b0;
          end
          // Re-request latches the newest phase, so stale steps are skipped
          if (reg_key_on && !noise_s && (pend_r || fetch_step_s)) begin
            state_r   <= ST_REQ;
            sram_req  <= 1'b1;
            sram_a    <= {CH_ID_V, next_phase_s};
            pend_r    <= 1'b0;
            discard_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            pend_r  <= 1'b0;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          sram_req  <= 1'b0;
          pend_r    <= 1'b0;
          discard_r <= 1'b0;
        end
      endcase
    end
  end

  assign phase = phase_r;

endmodule
